control_unit: RTL and testbench

Fetch/execute sequencer for the accumulator-style datapath. It drives the program memory address and latches the 16-bit instruction word, then decodes opcode [15:12], register select [11:10] and address field [9:0]. It issues one-cycle ALU enables, data-memory read/write strobes with a ready handshake, and register write-back. It sits between `program_memory` and the ALU/register-file/data-memory datapath, and runs one program pass per `start`.

---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/control_unit_if.sv | 48 ++++
 rtl/control_unit_decoder.sv | 43 ++++
 rtl/control_unit.sv | 139 +++++++++++++
 tb/tb_control_unit.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared definitions for the accumulator datapath sequencer.
//            Holds the opcode encodings, instruction field widths, the
//            control FSM state type, the instruction class type and an
//            opcode legality helper.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Instruction field widths (16-bit word: [15:12] op, [11:10] reg, [9:0] addr)
    localparam int OPCODE_W     = 4;
    localparam int REG_SEL_W    = 2;
    localparam int ADDR_FIELD_W = 10;

    // Opcode encodings
    localparam logic [OPCODE_W-1:0] OP_ADD      = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_SUBTRACT = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_AND      = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_OR       = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_XOR      = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_NOT      = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_LOAD     = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_STORE    = 4'b0111;
    localparam logic [OPCODE_W-1:0] OP_NOP      = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } ctrl_state_t;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_NOP     = 3'd3,
        CLS_ILLEGAL = 3'd4
    } instr_class_t;

    // 0000-0111 and 1111 are defined; 1000-1110 are not.
    function automatic logic is_legal_opcode(input logic [OPCODE_W-1:0] op);
        return (op[3] == 1'b0) || (op == OP_NOP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : control_unit_if
// Purpose  : Bundles the sequencer's program-memory, datapath-control and
//            status signals.
//   master : the control unit (drives PC, strobes, fields and status)
//   slave  : the surrounding memories/datapath (drive start, instruction,
//            mem_ready)
// Revision : 1.0 - initial release
// ============================================================================
interface control_unit_if #(
    parameter int BITS_FOR_INSTRUCTIONS = 5,
    parameter int INSTRUCTION_WIDTH     = 16
);
    import cpu_pkg::*;

    logic                              start;
    logic [BITS_FOR_INSTRUCTIONS-1:0]  instruction_address;
    logic [INSTRUCTION_WIDTH-1:0]      instruction;
    logic [OPCODE_W-1:0]               alu_op;
    logic                              alu_en;
    logic [REG_SEL_W-1:0]              reg_sel;
    logic [ADDR_FIELD_W-1:0]           mem_addr;
    logic                              mem_read;
    logic                              mem_write;
    logic                              mem_ready;
    logic                              reg_we;
    logic                              busy;
    logic                              halted;
    logic                              illegal;
    logic [BITS_FOR_INSTRUCTIONS:0]    retired_count;

    modport master (
        input  start, instruction, mem_ready,
        output instruction_address, alu_op, alu_en, reg_sel, mem_addr,
               mem_read, mem_write, reg_we, busy, halted, illegal,
               retired_count
    );

    modport slave (
        output start, instruction, mem_ready,
        input  instruction_address, alu_op, alu_en, reg_sel, mem_addr,
               mem_read, mem_write, reg_we, busy, halted, illegal,
               retired_count
    );

endinterface
`default_nettype wire

// File: rtl/control_unit_decoder.sv
`default_nettype none
// ============================================================================
// Module   : instruction_decoder
// Purpose  : Combinational split of the 16-bit instruction register into
//            opcode, register select and address field, plus a class used
//            by the sequencer to pick its path.
// Ports    : instr_i    - instruction register contents
//            opcode_o   - bits [15:12]
//            reg_sel_o  - bits [11:10]
//            addr_o     - bits [9:0]
//            class_o    - alu / load / store / nop / illegal
// Revision : 1.0 - initial release
// ============================================================================
module instruction_decoder
    import cpu_pkg::*;
(
    input  wire logic [15:0]             instr_i,
    output      logic [OPCODE_W-1:0]     opcode_o,
    output      logic [REG_SEL_W-1:0]    reg_sel_o,
    output      logic [ADDR_FIELD_W-1:0] addr_o,
    output      instr_class_t            class_o
);

    assign opcode_o  = instr_i[15:12];
    assign reg_sel_o = instr_i[11:10];
    assign addr_o    = instr_i[9:0];

    always_comb begin
        class_o = CLS_ILLEGAL;
        if (is_legal_opcode(instr_i[15:12])) begin
            case (instr_i[15:12])
                OP_ADD, OP_SUBTRACT, OP_AND,
                OP_OR, OP_XOR, OP_NOT:    class_o = CLS_ALU;
                OP_LOAD:                  class_o = CLS_LOAD;
                OP_STORE:                 class_o = CLS_STORE;
                OP_NOP:                   class_o = CLS_NOP;
                default:                  class_o = CLS_ILLEGAL;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Purpose  : Fetch/execute sequencer. Walks the program memory once per
//            start, issuing one-cycle ALU enables, held data-memory strobes
//            (released by mem_ready) and register write-back strobes.
// Ports    : clk  - rising-edge clock
//            rst  - synchronous active-high reset
//            bus  - control_unit_if.master (PC/instruction, datapath
//                   strobes and fields, mem_ready, busy/halted/illegal,
//                   retired_count)
// Revision : 1.0 - initial release
// ============================================================================
module control_unit
    import cpu_pkg::*;
#(
    parameter int BITS_FOR_INSTRUCTIONS  = 5,
    parameter int INSTRUCTION_WIDTH      = 16,
    parameter int NUMBER_OF_INSTRUCTIONS = 32
) (
    input  wire logic       clk,
    input  wire logic       rst,
    control_unit_if.master  bus
);

    localparam int RC_W = BITS_FOR_INSTRUCTIONS + 1;
    localparam logic [BITS_FOR_INSTRUCTIONS-1:0] c_last_pc =
        BITS_FOR_INSTRUCTIONS'(NUMBER_OF_INSTRUCTIONS - 1);

    ctrl_state_t                      state_q, state_d;
    logic [BITS_FOR_INSTRUCTIONS-1:0] pc_q, pc_d;
    logic [INSTRUCTION_WIDTH-1:0]     ir_q, ir_d;
    logic [RC_W-1:0]                  retired_q, retired_d;
    logic                             illegal_q, illegal_d;

    logic [OPCODE_W-1:0]     w_opcode;
    logic [REG_SEL_W-1:0]    w_reg_sel;
    logic [ADDR_FIELD_W-1:0] w_addr;
    instr_class_t            w_class;
    logic                    w_retire;
    logic                    w_op_phase;

    instruction_decoder u_decoder (
        .instr_i   (ir_q[15:0]),
        .opcode_o  (w_opcode),
        .reg_sel_o (w_reg_sel),
        .addr_o    (w_addr),
        .class_o   (w_class)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        illegal_d = illegal_q;
        w_retire  = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (bus.start) begin
                    state_d   = ST_FETCH;
                    pc_d      = '0;
                    retired_d = '0;
                    illegal_d = 1'b0;
                end
            end
            ST_FETCH: begin
                ir_d    = bus.instruction;
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                case (w_class)
                    CLS_ALU:             state_d = ST_WRITEBACK;
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    CLS_NOP:             w_retire = 1'b1;
                    default: begin
                        // Undefined opcode: stop the pass without retiring.
                        illegal_d = 1'b1;
                        state_d   = ST_HALT;
                    end
                endcase
            end
            ST_MEM: begin
                if (bus.mem_ready) begin
                    if (w_class == CLS_LOAD) state_d = ST_WRITEBACK;
                    else                     w_retire = 1'b1;
                end
            end
            ST_WRITEBACK: w_retire = 1'b1;
            default:      state_d  = ST_IDLE;
        endcase

        // The final address ends the pass with the PC parked on it.
        if (w_retire) begin
            retired_d = retired_q + RC_W'(1);
            if (pc_q == c_last_pc) begin
                state_d = ST_HALT;
            end else begin
                pc_d    = pc_q + BITS_FOR_INSTRUCTIONS'(1);
                state_d = ST_FETCH;
            end
        end
    end

    assign w_op_phase = (state_q == ST_EXECUTE) || (state_q == ST_MEM) ||
                        (state_q == ST_WRITEBACK);

    assign bus.instruction_address = pc_q;
    assign bus.alu_op    = w_op_phase ? w_opcode  : '0;
    assign bus.reg_sel   = w_op_phase ? w_reg_sel : '0;
    assign bus.mem_addr  = w_op_phase ? w_addr    : '0;
    assign bus.alu_en    = (state_q == ST_EXECUTE) && (w_class == CLS_ALU);
    assign bus.mem_read  = (state_q == ST_MEM) && (w_class == CLS_LOAD);
    assign bus.mem_write = (state_q == ST_MEM) && (w_class == CLS_STORE);
    assign bus.reg_we    = (state_q == ST_WRITEBACK);
    assign bus.busy      = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign bus.halted    = (state_q == ST_HALT);
    assign bus.illegal   = illegal_q;
    assign bus.retired_count = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit
// Purpose  : Scoreboard bench for control_unit. Stimulus loads a program
//            image and pushes the expected strobe cycles and end-of-pass
//            status into a queue; a monitor pops and compares whenever a
//            strobe is high or halted rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit;
    import cpu_pkg::*;

    localparam int B = 5;
    localparam int W = 16;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    control_unit_if #(.BITS_FOR_INSTRUCTIONS(B), .INSTRUCTION_WIDTH(W)) bus ();

    control_unit #(
        .BITS_FOR_INSTRUCTIONS (B),
        .INSTRUCTION_WIDTH     (W),
        .NUMBER_OF_INSTRUCTIONS(N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Combinational program memory
    logic [W-1:0] prog [N];
    assign bus.instruction = prog[bus.instruction_address];

    typedef struct {
        bit          halt;
        int          cyc;
        logic        alu_en;
        logic [3:0]  alu_op;
        logic        mem_read;
        logic        mem_write;
        logic [9:0]  mem_addr;
        logic        reg_we;
        logic [1:0]  reg_sel;
        logic [5:0]  retired;
        logic [4:0]  pc;
        logic        illegal;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;

    // Cycle index within a pass: the cycle after the start edge is 1 (FETCH).
    always @(posedge clk) cyc <= (bus.start === 1'b1) ? 1 : cyc + 1;

    // Data-memory responder: ready after ready_delay wait cycles.
    int ready_delay = 0;
    int wait_cnt    = 0;
    always @(negedge clk) begin
        if (rst || !(bus.mem_read === 1'b1 || bus.mem_write === 1'b1)) begin
            bus.mem_ready = 1'b0;
            wait_cnt      = 0;
        end else begin
            bus.mem_ready = (wait_cnt >= ready_delay);
            wait_cnt      = wait_cnt + 1;
        end
    end

    function automatic void push_strobe(int c, logic ae, logic [3:0] op,
                                        logic rd, logic wr, logic [9:0] ma,
                                        logic we, logic [1:0] rs);
        exp_t e;
        e = '{halt: 1'b0, cyc: c, alu_en: ae, alu_op: op, mem_read: rd,
              mem_write: wr, mem_addr: ma, reg_we: we, reg_sel: rs,
              retired: 6'd0, pc: 5'd0, illegal: 1'b0};
        q.push_back(e);
    endfunction

    function automatic void push_halt(int c, logic [5:0] r, logic [4:0] pc,
                                      logic il);
        exp_t e;
        e = '{halt: 1'b1, cyc: c, alu_en: 1'b0, alu_op: 4'd0, mem_read: 1'b0,
              mem_write: 1'b0, mem_addr: 10'd0, reg_we: 1'b0, reg_sel: 2'd0,
              retired: r, pc: pc, illegal: il};
        q.push_back(e);
    endfunction

    // Monitor
    exp_t e;
    logic prev_halted = 1'b0;
    logic strobe;
    always @(negedge clk) begin
        if (bus.mem_read === 1'b1 && bus.mem_write === 1'b1) begin
            vectors = vectors + 1;
            errors  = errors + 1;
            $display("FAIL rd_wr_exclusive cyc=%0d: mem_read and mem_write both high", cyc);
        end
        strobe = (bus.alu_en === 1'b1) || (bus.mem_read === 1'b1) ||
                 (bus.mem_write === 1'b1) || (bus.reg_we === 1'b1);
        if (strobe) begin
            vectors = vectors + 1;
            if (q.size() == 0 || q[0].halt) begin
                errors = errors + 1;
                $display("FAIL unexpected_strobe cyc=%0d: ae=%b rd=%b wr=%b we=%b, expected no strobe",
                         cyc, bus.alu_en, bus.mem_read, bus.mem_write, bus.reg_we);
            end else begin
                e = q.pop_front();
                if (cyc != e.cyc || bus.alu_en !== e.alu_en || bus.alu_op !== e.alu_op ||
                    bus.mem_read !== e.mem_read || bus.mem_write !== e.mem_write ||
                    bus.mem_addr !== e.mem_addr || bus.reg_we !== e.reg_we ||
                    bus.reg_sel !== e.reg_sel) begin
                    errors = errors + 1;
                    $display("FAIL strobe: got cyc=%0d ae=%b op=%h rd=%b wr=%b addr=%h we=%b rs=%h, expected cyc=%0d ae=%b op=%h rd=%b wr=%b addr=%h we=%b rs=%h",
                             cyc, bus.alu_en, bus.alu_op, bus.mem_read, bus.mem_write,
                             bus.mem_addr, bus.reg_we, bus.reg_sel,
                             e.cyc, e.alu_en, e.alu_op, e.mem_read, e.mem_write,
                             e.mem_addr, e.reg_we, e.reg_sel);
                end
            end
        end
        if (bus.halted === 1'b1 && !prev_halted) begin
            vectors = vectors + 1;
            if (q.size() == 0 || !q[0].halt) begin
                errors = errors + 1;
                $display("FAIL unexpected_halt cyc=%0d: halted rose, expected pending strobes=%0d",
                         cyc, q.size());
            end else begin
                e = q.pop_front();
                if (cyc != e.cyc || bus.retired_count !== e.retired ||
                    bus.instruction_address !== e.pc || bus.illegal !== e.illegal ||
                    bus.busy !== 1'b0) begin
                    errors = errors + 1;
                    $display("FAIL halt: got cyc=%0d retired=%0d pc=%0d illegal=%b busy=%b, expected cyc=%0d retired=%0d pc=%0d illegal=%b busy=0",
                             cyc, bus.retired_count, bus.instruction_address, bus.illegal,
                             bus.busy, e.cyc, e.retired, e.pc, e.illegal);
                end
            end
        end
        prev_halted = (bus.halted === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_halt(input int budget);
        int n;
        n = 0;
        while (bus.halted !== 1'b1 && n < budget) begin
            tick();
            n = n + 1;
        end
        if (bus.halted !== 1'b1) begin
            vectors = vectors + 1;
            errors  = errors + 1;
            $display("FAIL halt_timeout: halted=%b after %0d cycles, expected 1", bus.halted, budget);
        end
        tick();
        tick();
    endtask

    task automatic fill_nop();
        for (int i = 0; i < N; i++) prog[i] = 16'hF000;
    endtask

    task automatic check_quiet(input string name);
        check(name, {28'd0, bus.alu_en, bus.mem_read, bus.mem_write, bus.reg_we}, 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        rst       = 1'b1;
        fill_nop();
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("reset_busy",    {31'd0, bus.busy},    32'd0);
        check("reset_halted",  {31'd0, bus.halted},  32'd0);
        check("reset_illegal", {31'd0, bus.illegal}, 32'd0);
        check("reset_pc",      {27'd0, bus.instruction_address}, 32'd0);
        check("reset_retired", {26'd0, bus.retired_count}, 32'd0);
        check("reset_fields",  {14'd0, bus.alu_op, bus.reg_sel, bus.mem_addr, 2'd0}, 32'd0);
        check_quiet("reset_strobes");
        rst = 1'b0;
        tick();
        tick();
        check("idle_no_start_busy", {31'd0, bus.busy}, 32'd0);

        // All NOP: 64 cycles of work, HALT at pass cycle 65
        push_halt(65, 6'd32, 5'd31, 1'b0);
        pulse_start();
        check("pass1_busy", {31'd0, bus.busy}, 32'd1);
        wait_halt(200);
        check_quiet("nop_halt_strobes");

        // ADD r=1 addr 0x2A at address 0
        prog[0] = 16'h042A;
        push_strobe(2, 1'b1, 4'h0, 1'b0, 1'b0, 10'h02A, 1'b0, 2'd1);
        push_strobe(3, 1'b0, 4'h0, 1'b0, 1'b0, 10'h02A, 1'b1, 2'd1);
        push_halt(66, 6'd32, 5'd31, 1'b0);
        pulse_start();
        wait_halt(200);

        // LOAD r=3 addr 5 with three wait cycles
        fill_nop();
        prog[0] = 16'h6C05;
        ready_delay = 3;
        for (int c = 3; c <= 6; c++)
            push_strobe(c, 1'b0, 4'h6, 1'b1, 1'b0, 10'h005, 1'b0, 2'd3);
        push_strobe(7, 1'b0, 4'h6, 1'b0, 1'b0, 10'h005, 1'b1, 2'd3);
        push_halt(70, 6'd32, 5'd31, 1'b0);
        pulse_start();
        wait_halt(200);

        // STORE r=2 addr 0x3FF at the last address, ready immediately
        fill_nop();
        prog[31] = 16'h7BFF;
        ready_delay = 0;
        push_strobe(65, 1'b0, 4'h7, 1'b0, 1'b1, 10'h3FF, 1'b0, 2'd2);
        push_halt(66, 6'd32, 5'd31, 1'b0);
        pulse_start();
        wait_halt(200);

        // Illegal opcode 1010 at address 3
        fill_nop();
        prog[3] = 16'hA123;
        push_halt(9, 6'd3, 5'd3, 1'b1);
        pulse_start();
        wait_halt(200);
        check("illegal_sticky", {31'd0, bus.illegal}, 32'd1);
        check("illegal_pc",     {27'd0, bus.instruction_address}, 32'd3);

        // Reset during a MEM wait
        fill_nop();
        prog[0] = 16'h6C05;
        ready_delay = 100;
        push_strobe(3, 1'b0, 4'h6, 1'b1, 1'b0, 10'h005, 1'b0, 2'd3);
        push_strobe(4, 1'b0, 4'h6, 1'b1, 1'b0, 10'h005, 1'b0, 2'd3);
        pulse_start();
        check("restart_clears_illegal", {31'd0, bus.illegal}, 32'd0);
        check("restart_retired",        {26'd0, bus.retired_count}, 32'd0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
        check("rst_busy",     {31'd0, bus.busy},     32'd0);
        check("rst_pc",       {27'd0, bus.instruction_address}, 32'd0);
        check("rst_halted",   {31'd0, bus.halted},   32'd0);
        rst = 1'b0;
        ready_delay = 0;
        prog[0] = 16'h0800;
        push_strobe(2, 1'b1, 4'h0, 1'b0, 1'b0, 10'h000, 1'b0, 2'd2);
        push_strobe(3, 1'b0, 4'h0, 1'b0, 1'b0, 10'h000, 1'b1, 2'd2);
        push_halt(66, 6'd32, 5'd31, 1'b0);
        tick();
        pulse_start();
        wait_halt(200);

        while (q.size() > 0) begin
            e = q.pop_front();
            vectors = vectors + 1;
            errors  = errors + 1;
            $display("FAIL missing_event: expected halt=%0d cyc=%0d never observed", e.halt, e.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
